// File: rtl/floo_narrow_wide_pkg.sv
// Flit and link types shared by the narrow/wide endpoint port.
//   floo_*_chan_t : flit payloads (header with last flag + data)
//   floo_*_t      : link bundles (valid, ready, flit)
package floo_narrow_wide_pkg;

    localparam int unsigned DstIdWidth      = 4;
    localparam int unsigned NarrowDataWidth = 32;
    localparam int unsigned WideDataWidth   = 64;

    typedef struct packed {
        logic                  last;
        logic [DstIdWidth-1:0] dst_id;
    } floo_hdr_t;

    typedef struct packed {
        floo_hdr_t                  hdr;
        logic [NarrowDataWidth-1:0] payload;
    } floo_req_chan_t;

    typedef struct packed {
        floo_hdr_t                  hdr;
        logic [NarrowDataWidth-1:0] payload;
    } floo_rsp_chan_t;

    typedef struct packed {
        floo_hdr_t                hdr;
        logic [WideDataWidth-1:0] payload;
    } floo_wide_chan_t;

    typedef struct packed {
        logic           valid;
        logic           ready;
        floo_req_chan_t req;
    } floo_req_t;

    typedef struct packed {
        logic           valid;
        logic           ready;
        floo_rsp_chan_t rsp;
    } floo_rsp_t;

    typedef struct packed {
        logic            valid;
        logic            ready;
        floo_wide_chan_t wide;
    } floo_wide_t;

endpackage

// File: rtl/floo_ep_elastic_buf.sv
// Two-entry elastic buffer (small FIFO) with valid/ready on both sides.
//   valid_i/ready_o/data_i : upstream side; ready_o is "not full" from flops only
//   valid_o/ready_i/data_o : downstream side; valid_o is "not empty"
// Full throughput with one cycle of latency; head data held while stalled.
module floo_ep_elastic_buf #(
    parameter type data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    output logic  ready_o,
    input  data_t data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output data_t data_o
);

    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    data_t      mem_q [2];
    data_t      mem_d [2];
    logic       push, pop;

    assign valid_o = (cnt_q != 2'd0);
    assign ready_o = (cnt_q != 2'd2);
    assign data_o  = mem_q[rd_ptr_q];
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // Pointer, occupancy and storage update.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

endmodule

// File: rtl/floo_narrow_wide_ep_port.sv
// Endpoint side of a narrow/wide router local port.
//   req_*      : local narrow requests  -> floo_req_o (throttled by outstanding limit)
//   rsp_*      : floo_rsp_i             -> local narrow responses
//   wide_*_i   : local wide flits       -> floo_wide_o
//   wide_*_o   : floo_wide_i            -> local wide flits
//   outstanding_o : transactions issued (last req flit) but not closed (last rsp flit)
//   underflow_o   : sticky counter error flag
module floo_narrow_wide_ep_port
    import floo_narrow_wide_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1),
    parameter bit          EnLimit        = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  floo_req_chan_t      req_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output floo_rsp_chan_t      rsp_o,
    input  logic                wide_valid_i,
    output logic                wide_ready_o,
    input  floo_wide_chan_t     wide_i,
    output logic                wide_valid_o,
    input  logic                wide_ready_i,
    output floo_wide_chan_t     wide_o,
    output floo_req_t           floo_req_o,
    input  floo_req_t           floo_req_i,
    input  floo_rsp_t           floo_rsp_i,
    output floo_rsp_t           floo_rsp_o,
    output floo_wide_t          floo_wide_o,
    input  floo_wide_t          floo_wide_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                underflow_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                in_burst_q, in_burst_d;
    logic                underflow_q, underflow_d;

    logic            limit_ok;
    logic            req_buf_ready, req_hs, rsp_hs, inc, dec;
    logic            req_out_valid, wide_out_valid, rsp_buf_ready, wide_in_ready;
    floo_req_chan_t  req_out_data;
    floo_wide_chan_t wide_out_data;
    logic            unused_link_fields;

    // Only the ready of the incoming request link and nothing of the response link's ready is consumed.
    assign unused_link_fields = ^{floo_req_i.valid, floo_req_i.req, floo_rsp_i.ready};

    // Once a burst has started it always completes, so the gate only blocks new transactions.
    assign limit_ok    = !EnLimit || in_burst_q || (cnt_q < MaxCnt);
    assign req_ready_o = req_buf_ready && limit_ok;
    assign req_hs      = req_valid_i && req_ready_o;
    assign rsp_hs      = floo_rsp_i.valid && rsp_buf_ready;
    assign inc         = req_hs && req_i.hdr.last;
    assign dec         = rsp_hs && floo_rsp_i.rsp.hdr.last;

    floo_ep_elastic_buf #(.data_t(floo_req_chan_t)) i_req_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (req_valid_i && limit_ok),
        .ready_o (req_buf_ready),
        .data_i  (req_i),
        .valid_o (req_out_valid),
        .ready_i (floo_req_i.ready),
        .data_o  (req_out_data)
    );

    floo_ep_elastic_buf #(.data_t(floo_wide_chan_t)) i_wide_out_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (wide_valid_i),
        .ready_o (wide_ready_o),
        .data_i  (wide_i),
        .valid_o (wide_out_valid),
        .ready_i (floo_wide_i.ready),
        .data_o  (wide_out_data)
    );

    floo_ep_elastic_buf #(.data_t(floo_rsp_chan_t)) i_rsp_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (floo_rsp_i.valid),
        .ready_o (rsp_buf_ready),
        .data_i  (floo_rsp_i.rsp),
        .valid_o (rsp_valid_o),
        .ready_i (rsp_ready_i),
        .data_o  (rsp_o)
    );

    floo_ep_elastic_buf #(.data_t(floo_wide_chan_t)) i_wide_in_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (floo_wide_i.valid),
        .ready_o (wide_in_ready),
        .data_i  (floo_wide_i.wide),
        .valid_o (wide_valid_o),
        .ready_i (wide_ready_i),
        .data_o  (wide_o)
    );

    // Link bundle assembly.
    always_comb begin
        floo_req_o        = '0;
        floo_req_o.valid  = req_out_valid;
        floo_req_o.req    = req_out_data;
        floo_rsp_o        = '0;
        floo_rsp_o.ready  = rsp_buf_ready;
        floo_wide_o       = '0;
        floo_wide_o.valid = wide_out_valid;
        floo_wide_o.wide  = wide_out_data;
        floo_wide_o.ready = wide_in_ready;
    end

    // Outstanding counter, burst tracking and sticky error.
    always_comb begin
        cnt_d       = cnt_q;
        in_burst_d  = in_burst_q;
        underflow_d = underflow_q;
        if (req_hs) begin
            in_burst_d = !req_i.hdr.last;
        end
        case ({inc, dec})
            2'b11: begin
                // A close at zero is absorbed by the simultaneous issue.
                if (cnt_q == '0) cnt_d = CntWidth'(1);
            end
            2'b10: begin
                if (cnt_q == MaxCnt) underflow_d = 1'b1;
                else                 cnt_d       = cnt_q + CntWidth'(1);
            end
            2'b01: begin
                if (cnt_q == '0) underflow_d = 1'b1;
                else             cnt_d       = cnt_q - CntWidth'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            in_burst_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            in_burst_q  <= in_burst_d;
            underflow_q <= underflow_d;
        end
    end

    assign outstanding_o = cnt_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_floo_narrow_wide_ep_port.sv
module tb_floo_narrow_wide_ep_port;
    import floo_narrow_wide_pkg::*;

    localparam int unsigned MAX = 2;
    localparam int unsigned CW  = $clog2(MAX + 1);

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    floo_req_chan_t  req_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    floo_rsp_chan_t  rsp_o;
    logic            wide_valid_i = 1'b0;
    logic            wide_ready_o;
    floo_wide_chan_t wide_i = '0;
    logic            wide_valid_o;
    logic            wide_ready_i = 1'b0;
    floo_wide_chan_t wide_o;
    floo_req_t       floo_req_o;
    floo_req_t       floo_req_i = '0;
    floo_rsp_t       floo_rsp_i = '0;
    floo_rsp_t       floo_rsp_o;
    floo_wide_t      floo_wide_o;
    floo_wide_t      floo_wide_i = '0;
    logic [CW-1:0]   outstanding_o;
    logic            underflow_o;

    always #5 clk = ~clk;

    floo_narrow_wide_ep_port #(.MaxOutstanding(MAX), .EnLimit(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_o(rsp_o),
        .wide_valid_i(wide_valid_i), .wide_ready_o(wide_ready_o), .wide_i(wide_i),
        .wide_valid_o(wide_valid_o), .wide_ready_i(wide_ready_i), .wide_o(wide_o),
        .floo_req_o(floo_req_o), .floo_req_i(floo_req_i),
        .floo_rsp_i(floo_rsp_i), .floo_rsp_o(floo_rsp_o),
        .floo_wide_o(floo_wide_o), .floo_wide_i(floo_wide_i),
        .outstanding_o(outstanding_o), .underflow_o(underflow_o)
    );

    // Stimulus waiting to be offered, one queue per input channel.
    floo_req_chan_t  pend_req[$];
    floo_rsp_chan_t  pend_rsp[$];
    floo_wide_chan_t pend_wo[$];
    floo_wide_chan_t pend_wi[$];

    // Reference model: per-channel FIFO contents plus transaction bookkeeping.
    floo_req_chan_t  m_req_q[$];
    floo_rsp_chan_t  m_rsp_q[$];
    floo_wide_chan_t m_wo_q[$];
    floo_wide_chan_t m_wi_q[$];
    int              m_cnt;
    bit              m_burst;
    bit              m_uf;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wv_cycles, rv_cycles, wiv_cycles, first_wv, last_wv, phase_start;
    floo_req_chan_t held;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic floo_req_chan_t mk_req(input bit last);
        floo_req_chan_t f;
        f.hdr.last   = last;
        f.hdr.dst_id = 4'($urandom);
        f.payload    = 32'($urandom);
        return f;
    endfunction

    function automatic floo_rsp_chan_t mk_rsp(input bit last);
        floo_rsp_chan_t f;
        f.hdr.last   = last;
        f.hdr.dst_id = 4'($urandom);
        f.payload    = 32'($urandom);
        return f;
    endfunction

    function automatic floo_wide_chan_t mk_wide();
        floo_wide_chan_t f;
        f.hdr.last   = 1'($urandom);
        f.hdr.dst_id = 4'($urandom);
        f.payload    = {32'($urandom), 32'($urandom)};
        return f;
    endfunction

    function automatic bit gate();
        return m_burst || (m_cnt < int'(MAX));
    endfunction

    task automatic drive();
        req_valid_i       = (pend_req.size() != 0);
        req_i             = req_valid_i ? pend_req[0] : '0;
        wide_valid_i      = (pend_wo.size() != 0);
        wide_i            = wide_valid_i ? pend_wo[0] : '0;
        floo_rsp_i.valid  = (pend_rsp.size() != 0);
        floo_rsp_i.rsp    = floo_rsp_i.valid ? pend_rsp[0] : '0;
        floo_wide_i.valid = (pend_wi.size() != 0);
        floo_wide_i.wide  = floo_wide_i.valid ? pend_wi[0] : '0;
    endtask

    task automatic check_all();
        chk("req_ready", 128'(req_ready_o), 128'((m_req_q.size() < 2) && gate()));
        chk("req_link_valid", 128'(floo_req_o.valid), 128'(m_req_q.size() != 0));
        if (m_req_q.size() != 0) chk("req_link_data", 128'(floo_req_o.req), 128'(m_req_q[0]));
        chk("req_link_ready_zero", 128'(floo_req_o.ready), 128'(0));
        chk("wide_ready", 128'(wide_ready_o), 128'(m_wo_q.size() < 2));
        chk("wide_link_valid", 128'(floo_wide_o.valid), 128'(m_wo_q.size() != 0));
        if (m_wo_q.size() != 0) chk("wide_link_data", 128'(floo_wide_o.wide), 128'(m_wo_q[0]));
        chk("rsp_link_ready", 128'(floo_rsp_o.ready), 128'(m_rsp_q.size() < 2));
        chk("rsp_link_idle", 128'({floo_rsp_o.valid, floo_rsp_o.rsp}), 128'(0));
        chk("rsp_valid", 128'(rsp_valid_o), 128'(m_rsp_q.size() != 0));
        if (m_rsp_q.size() != 0) chk("rsp_data", 128'(rsp_o), 128'(m_rsp_q[0]));
        chk("wide_in_ready", 128'(floo_wide_o.ready), 128'(m_wi_q.size() < 2));
        chk("wide_out_valid", 128'(wide_valid_o), 128'(m_wi_q.size() != 0));
        if (m_wi_q.size() != 0) chk("wide_out_data", 128'(wide_o), 128'(m_wi_q[0]));
        chk("outstanding", 128'(outstanding_o), 128'(m_cnt));
        chk("underflow", 128'(underflow_o), 128'(m_uf));
    endtask

    // One clock: offer pending stimulus, check outputs, then advance the model.
    task automatic cycle();
        bit req_in, req_out, wo_in, wo_out, rsp_in, rsp_out, wi_in, wi_out, inc, dec;
        drive();
        check_all();
        if (floo_wide_o.valid) begin
            wv_cycles++;
            if (first_wv < 0) first_wv = cyc;
            last_wv = cyc;
        end
        if (rsp_valid_o)  rv_cycles++;
        if (wide_valid_o) wiv_cycles++;
        req_in  = (pend_req.size() != 0) && (m_req_q.size() < 2) && gate();
        req_out = (m_req_q.size() != 0) && floo_req_i.ready;
        wo_in   = (pend_wo.size() != 0) && (m_wo_q.size() < 2);
        wo_out  = (m_wo_q.size() != 0) && floo_wide_i.ready;
        rsp_in  = (pend_rsp.size() != 0) && (m_rsp_q.size() < 2);
        rsp_out = (m_rsp_q.size() != 0) && rsp_ready_i;
        wi_in   = (pend_wi.size() != 0) && (m_wi_q.size() < 2);
        wi_out  = (m_wi_q.size() != 0) && wide_ready_i;
        inc     = req_in && pend_req[0].hdr.last;
        dec     = rsp_in && pend_rsp[0].hdr.last;
        @(posedge clk); #1;
        cyc++;
        if (req_out) void'(m_req_q.pop_front());
        if (wo_out)  void'(m_wo_q.pop_front());
        if (rsp_out) void'(m_rsp_q.pop_front());
        if (wi_out)  void'(m_wi_q.pop_front());
        if (req_in) begin
            m_burst = !pend_req[0].hdr.last;
            m_req_q.push_back(pend_req.pop_front());
        end
        if (wo_in)  m_wo_q.push_back(pend_wo.pop_front());
        if (rsp_in) m_rsp_q.push_back(pend_rsp.pop_front());
        if (wi_in)  m_wi_q.push_back(pend_wi.pop_front());
        // Transactions issued minus transactions closed, clamped to [0, MAX].
        if (inc && dec) begin
            if (m_cnt == 0) m_cnt = 1;
        end else if (inc) begin
            if (m_cnt == int'(MAX)) m_uf = 1'b1;
            else m_cnt++;
        end else if (dec) begin
            if (m_cnt == 0) m_uf = 1'b1;
            else m_cnt--;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        pend_req.delete(); pend_rsp.delete(); pend_wo.delete(); pend_wi.delete();
        m_req_q.delete(); m_rsp_q.delete(); m_wo_q.delete(); m_wi_q.delete();
        m_cnt = 0; m_burst = 1'b0; m_uf = 1'b0;
        drive();
        #1;
        check_all();
        chk("rst_req_ready", 128'(req_ready_o), 128'(1));
        chk("rst_wide_ready", 128'(wide_ready_o), 128'(1));
        chk("rst_rsp_link_ready", 128'(floo_rsp_o.ready), 128'(1));
        chk("rst_valids", 128'({floo_req_o.valid, floo_wide_o.valid, rsp_valid_o, wide_valid_o}), 128'(0));
        chk("rst_counter_flags", 128'({outstanding_o, underflow_o}), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_ni = 1'b1;
    endtask

    initial begin
        // Reset and idle.
        do_reset();
        run(2);

        // Throughput on both wide directions and the response path.
        floo_req_i.ready  = 1'b1;
        floo_wide_i.ready = 1'b1;
        wide_ready_i      = 1'b1;
        rsp_ready_i       = 1'b1;
        wv_cycles = 0; rv_cycles = 0; wiv_cycles = 0; first_wv = -1; last_wv = -1;
        for (int i = 0; i < 16; i++) begin
            pend_wo.push_back(mk_wide());
            pend_wi.push_back(mk_wide());
            pend_rsp.push_back(mk_rsp(1'b0));
        end
        phase_start = cyc;
        run(20);
        chk("thru_wide_cycles", 128'(wv_cycles), 128'(16));
        chk("thru_wide_first", 128'(first_wv), 128'(phase_start + 1));
        chk("thru_wide_span", 128'(last_wv - first_wv + 1), 128'(16));
        chk("thru_rsp_cycles", 128'(rv_cycles), 128'(16));
        chk("thru_wide_in_cycles", 128'(wiv_cycles), 128'(16));

        // Backpressure on the request link: two flits fit, the third stalls.
        floo_req_i.ready = 1'b0;
        pend_req.push_back(mk_req(1'b0));
        held = pend_req[0];
        pend_req.push_back(mk_req(1'b0));
        pend_req.push_back(mk_req(1'b1));
        run(2);
        chk("bp_ready_low", 128'(req_ready_o), 128'(0));
        for (int i = 0; i < 3; i++) begin
            run(1);
            chk("bp_data_stable", 128'(floo_req_o.req), 128'(held));
        end
        floo_req_i.ready = 1'b1;
        run(4);
        chk("bp_count", 128'(outstanding_o), 128'(1));
        pend_rsp.push_back(mk_rsp(1'b1));
        run(3);
        chk("bp_closed", 128'(outstanding_o), 128'(0));

        // Limit: third single-flit request waits for a closing response.
        for (int i = 0; i < 3; i++) pend_req.push_back(mk_req(1'b1));
        run(6);
        chk("limit_at_max", 128'(outstanding_o), 128'(2));
        chk("limit_stalled", 128'(req_ready_o), 128'(0));
        pend_rsp.push_back(mk_rsp(1'b1));
        run(1);
        chk("limit_after_rsp", 128'(outstanding_o), 128'(1));
        run(1);
        chk("limit_refilled", 128'(outstanding_o), 128'(2));
        run(2);

        // A burst begun below the limit completes even as it reaches the limit.
        pend_rsp.push_back(mk_rsp(1'b1));
        run(2);
        chk("burst_start_cnt", 128'(outstanding_o), 128'(1));
        for (int i = 0; i < 4; i++) pend_req.push_back(mk_req(i == 3));
        run(6);
        chk("burst_done_cnt", 128'(outstanding_o), 128'(2));
        pend_req.push_back(mk_req(1'b1));
        run(3);
        chk("burst_next_stalled", 128'(req_ready_o), 128'(0));
        for (int i = 0; i < 3; i++) pend_rsp.push_back(mk_rsp(1'b1));
        run(8);
        chk("burst_drained", 128'(outstanding_o), 128'(0));

        // Underflow, then simultaneous issue and close.
        pend_rsp.push_back(mk_rsp(1'b1));
        run(3);
        chk("uf_flag", 128'(underflow_o), 128'(1));
        chk("uf_count", 128'(outstanding_o), 128'(0));
        pend_req.push_back(mk_req(1'b1));
        run(2);
        pend_req.push_back(mk_req(1'b1));
        pend_rsp.push_back(mk_rsp(1'b1));
        run(1);
        chk("simul_cnt", 128'(outstanding_o), 128'(1));
        run(3);

        // Random traffic and random downstream readiness.
        for (int i = 0; i < 80; i++) begin
            floo_req_i.ready  = 1'($urandom);
            floo_wide_i.ready = 1'($urandom);
            wide_ready_i      = 1'($urandom);
            rsp_ready_i       = 1'($urandom);
            if (pend_req.size() < 3 && $urandom_range(0, 1) == 1) pend_req.push_back(mk_req(1'($urandom)));
            if (pend_rsp.size() < 3 && $urandom_range(0, 2) == 0) pend_rsp.push_back(mk_rsp(1'($urandom)));
            if (pend_wo.size() < 3 && $urandom_range(0, 1) == 1)  pend_wo.push_back(mk_wide());
            if (pend_wi.size() < 3 && $urandom_range(0, 1) == 1)  pend_wi.push_back(mk_wide());
            cycle();
        end

        // Reset with flits buffered everywhere.
        floo_req_i.ready = 1'b0; floo_wide_i.ready = 1'b0; wide_ready_i = 1'b0; rsp_ready_i = 1'b0;
        pend_rsp.push_back(mk_rsp(1'b1));
        for (int i = 0; i < 2; i++) begin
            pend_req.push_back(mk_req(1'b0));
            pend_wo.push_back(mk_wide());
            pend_wi.push_back(mk_wide());
            pend_rsp.push_back(mk_rsp(1'b0));
        end
        run(3);
        do_reset();
        run(1);

        // Issue and close in the same cycle at zero: count 1, no error.
        floo_req_i.ready = 1'b1; floo_wide_i.ready = 1'b1; wide_ready_i = 1'b1; rsp_ready_i = 1'b1;
        pend_req.push_back(mk_req(1'b1));
        pend_rsp.push_back(mk_rsp(1'b1));
        run(1);
        chk("zero_simul_cnt", 128'(outstanding_o), 128'(1));
        chk("zero_simul_uf", 128'(underflow_o), 128'(0));
        pend_rsp.push_back(mk_rsp(1'b1));
        run(3);
        chk("final_cnt", 128'(outstanding_o), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
